// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding and the reverse double-dabble correction constants.
`timescale 1ns/1ps
package bcd_to_binary_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH    = 4'd8;
    localparam logic [3:0] ADJ_VAL       = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational reverse double-dabble cell: a shifted BCD nibble of 8 or more
// had a ten's weight carried into it, so pulling 3 restores a valid digit.
`timescale 1ns/1ps
module bcd_digit_adjust
    import bcd_to_binary_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] result
);

    assign result = (digit >= ADJ_THRESH) ? (digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift
// plus per-digit correction per clock, behind a start/busy/done handshake.
`timescale 1ns/1ps
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t                state;
    logic [4*DIGITS-1:0]   bcd_reg;
    logic [BIN_W-1:0]      bin_reg;
    logic [CNT_W-1:0]      cnt;

    logic [4*DIGITS-1:0]   shifted_bcd;
    logic [4*DIGITS-1:0]   adjusted_bcd;
    logic [BIN_W-1:0]      shifted_bin;
    logic                  bad_digit;

    // The BCD LSB falls into the binary MSB; zero fills the top of the BCD side.
    assign shifted_bcd = {1'b0, bcd_reg[4*DIGITS-1:1]};
    assign shifted_bin = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit  (shifted_bcd[4*g +: 4]),
            .result (adjusted_bcd[4*g +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            state   <= DONE;
                            bin_out <= '0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            bcd_reg <= bcd_in;
                            bin_reg <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= adjusted_bcd;
                    bin_reg <= shifted_bin;
                    cnt     <= cnt + CNT_W'(1);
                    // The final shift's result goes straight to the output register.
                    if (cnt == LAST_CNT) begin
                        state   <= DONE;
                        cnt     <= '0;
                        bin_out <= shifted_bin;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: vector table, handshake corner
// sequences and randomized conversions against a decimal-arithmetic model.
`timescale 1ns/1ps
module tb_bcd_to_binary_seq;

    localparam int TIMEOUT = 60;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic [15:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int passes;
    int overlapCount;
    int cycle;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] bin;
        logic        err;
    } vec_t;

    vec_t vectors [10];

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // busy and done must never be seen high in the same cycle.
    initial overlapCount = 0;
    always @(negedge clk) begin
        if (busy && done) overlapCount <= overlapCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        else
            passes++;
    endtask

    // Reference: read the digits as a decimal number; any digit above 9 is an error.
    function automatic void bcdModel(input logic [15:0] bcd, output logic [15:0] bin,
                                     output logic bad);
        int value;
        int d;
        value = 0;
        bad   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            value = value * 10 + d;
        end
        bin = bad ? 16'd0 : value[15:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    // latency counts clock edges after the accepting edge until done is visible.
    task automatic applyStimulus(input logic [15:0] bcd, output int latency,
                                 output int busyCycles);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start      = 1'b0;
        latency    = 0;
        busyCycles = 0;
        while (!done && latency < TIMEOUT) begin
            if (busy) busyCycles++;
            @(negedge clk);
            latency++;
        end
        if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] bcd,
                               input logic [15:0] expBin, input logic expErr);
        int lat;
        int bc;
        applyStimulus(bcd, lat, bc);
        checkOutput({tag, "_bin"}, bin_out, expBin);
        checkOutput({tag, "_err"}, err, expErr);
        checkOutput({tag, "_latency"}, lat, expErr ? 0 : 16);
        checkOutput({tag, "_busy_cycles"}, bc, expErr ? 0 : 16);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int doneCount;
        int busySeen;
        int doneTimes [3];
        int found;
        logic [15:0] rbcd;
        logic [15:0] rbin;
        logic        rerr;

        checks = 0;
        passes = 0;

        vectors[0] = '{16'h9999, 16'h270F, 1'b0};
        vectors[1] = '{16'h0000, 16'h0000, 1'b0};
        vectors[2] = '{16'h0255, 16'h00FF, 1'b0};
        vectors[3] = '{16'h1000, 16'h03E8, 1'b0};
        vectors[4] = '{16'h12A4, 16'h0000, 1'b1};
        vectors[5] = '{16'h0042, 16'h002A, 1'b0};
        vectors[6] = '{16'h0123, 16'h007B, 1'b0};
        vectors[7] = '{16'h5678, 16'h162E, 1'b0};
        vectors[8] = '{16'hF000, 16'h0000, 1'b1};
        vectors[9] = '{16'h0009, 16'h0009, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_bin", bin_out, 16'h0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_err", err, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            runAndCheck($sformatf("vec%0d", i), vectors[i].bcd, vectors[i].bin, vectors[i].err);
        end

        // start toggling and bcd_in changing during SHIFT and DONE must be ignored.
        start  = 1'b1;
        bcd_in = 16'h0123;
        @(negedge clk);
        found = 0;
        while (!done && found < TIMEOUT) begin
            start  = ~start;
            bcd_in = 16'h9999;
            @(negedge clk);
            found++;
        end
        checkOutput("ignore_latency", found, 16);
        checkOutput("ignore_bin", bin_out, 16'h007B);
        checkOutput("ignore_err", err, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        doneCount = 0;
        busySeen  = 0;
        repeat (20) begin
            if (done) doneCount++;
            if (busy) busySeen++;
            @(negedge clk);
        end
        checkOutput("ignore_no_second_done", doneCount, 0);
        checkOutput("ignore_no_second_busy", busySeen, 0);
        checkOutput("ignore_bin_held", bin_out, 16'h007B);

        // Reset in the middle of a conversion aborts it without a done.
        start  = 1'b1;
        bcd_in = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_bin", bin_out, 16'h0);
        checkOutput("abort_done", done, 1'b0);
        reset     = 1'b0;
        doneCount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort_no_done", doneCount, 0);
        runAndCheck("after_abort", 16'h5678, 16'h162E, 1'b0);

        // start held high: back-to-back conversions every 18 cycles.
        start  = 1'b1;
        bcd_in = 16'h0001;
        found  = 0;
        for (int n = 0; n < 80 && found < 3; n++) begin
            @(negedge clk);
            if (done) begin
                doneTimes[found] = cycle;
                checkOutput($sformatf("held_bin%0d", found), bin_out, 16'h0001);
                found++;
            end
        end
        start = 1'b0;
        checkOutput("held_done_count", found, 3);
        if (found == 3) begin
            checkOutput("held_spacing0", doneTimes[1] - doneTimes[0], 18);
            checkOutput("held_spacing1", doneTimes[2] - doneTimes[1], 18);
        end
        repeat (3) @(negedge clk);

        for (int r = 0; r < 30; r++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 7) == 0)
                    rbcd[4*d +: 4] = 4'($urandom_range(10, 15));
                else
                    rbcd[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            bcdModel(rbcd, rbin, rerr);
            runAndCheck($sformatf("rand%0d_%04h", r, rbcd), rbcd, rbin, rerr);
        end

        checkOutput("busy_done_exclusive", overlapCount, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
